sna_request_sequencer: RTL and testbench

//  Sequences NoC request flits into AXI4-Lite transactions on the slave network-adapter (SNA) request flow.

---
 rtl/sna_request_sequencer_if.sv | 39 +++
 rtl/sna_request_sequencer.sv | 204 ++++++++++++++++++++
 tb/tb_sna_request_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sna_request_sequencer_if.sv
// Request-flow bundle between the NoC flit source, the AXI4-Lite slave
// and the response flow, as seen by the SNA request sequencer.
interface sna_request_sequencer_if;
  logic [33:0] flit_in;
  logic        flit_valid;
  logic        flit_ready;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  rsp_pov_addr;
  logic        rsp_is_write;
  logic        rsp_done;
  logic        busy;
  logic        proto_err;
  logic        timeout_err;

  // Sequencer side of the bundle.
  modport slave (
    input  flit_in, flit_valid, AWREADY, WREADY, ARREADY, rsp_done,
    output flit_ready, AWADDR, AWVALID, WDATA, WSTRB, WVALID,
           ARADDR, ARVALID, rsp_pov_addr, rsp_is_write,
           busy, proto_err, timeout_err
  );

  // Environment side: flit source, AXI slave and response flow.
  modport master (
    output flit_in, flit_valid, AWREADY, WREADY, ARREADY, rsp_done,
    input  flit_ready, AWADDR, AWVALID, WDATA, WSTRB, WVALID,
           ARADDR, ARVALID, rsp_pov_addr, rsp_is_write,
           busy, proto_err, timeout_err
  );
endinterface

// File: rtl/sna_request_sequencer.sv
// SNA request sequencer: collects header/address/data flits and issues a
// single outstanding AXI4-Lite write (AW+W) or read (AR), then waits for the
// response flow to report completion before accepting the next header.
module sna_request_sequencer #(
  parameter int         TIMEOUT   = 1024,
  parameter logic [3:0] WSTRB_ALL = 4'hF
) (
  input logic                     ACLK,
  input logic                     ARESETn,
  sna_request_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, ISSUE_W, ISSUE_R, WAIT_RSP
  } state_t;

  localparam logic [1:0] T_HDR  = 2'b10;
  localparam logic [1:0] T_ADDR = 2'b00;
  localparam logic [1:0] T_DATA = 2'b01;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  // Counter value during the last cycle that is still inside the budget.
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t            state_q, state_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              arvalid_q, arvalid_d;
  logic              proto_err_q, proto_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [3:0]        pov_q, pov_d;
  logic              is_write_q, is_write_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              flit_ready;
  logic              accept;
  logic [1:0]        ftype;
  logic              aw_hs, w_hs, ar_hs;
  logic              to_hit;

  assign flit_ready = (state_q == IDLE) || (state_q == ADDR) || (state_q == DATA);
  assign accept     = bus.flit_valid & flit_ready;
  assign ftype      = bus.flit_in[33:32];
  assign aw_hs      = awvalid_q & bus.AWREADY;
  assign w_hs       = wvalid_q & bus.WREADY;
  assign ar_hs      = arvalid_q & bus.ARREADY;
  // A partial handshake can push the counter one past the limit, hence >=.
  assign to_hit     = TO_EN && (cnt_q >= CNT_LAST);

  // Next-state and registered-output decode for the flit/AXI sequencing FSM.
  always_comb begin
    state_d       = state_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    arvalid_d     = arvalid_q;
    proto_err_d   = 1'b0;
    timeout_err_d = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;
    pov_d         = pov_q;
    is_write_d    = is_write_q;
    cnt_d         = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ftype == T_HDR) begin
            pov_d      = bus.flit_in[24:21];
            is_write_d = bus.flit_in[20];
            state_d    = ADDR;
          end else begin
            proto_err_d = 1'b1;
          end
        end
      end
      ADDR: begin
        if (accept) begin
          if (ftype == T_ADDR) begin
            addr_d = bus.flit_in[31:0];
            if (is_write_q) begin
              state_d = DATA;
            end else begin
              state_d   = ISSUE_R;
              arvalid_d = 1'b1;
              cnt_d     = '0;
            end
          end else if (ftype == T_HDR) begin
            proto_err_d = 1'b1;
            pov_d       = bus.flit_in[24:21];
            is_write_d  = bus.flit_in[20];
          end else begin
            proto_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      DATA: begin
        if (accept) begin
          if (ftype == T_DATA) begin
            data_d    = bus.flit_in[31:0];
            state_d   = ISSUE_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            cnt_d     = '0;
          end else if (ftype == T_HDR) begin
            proto_err_d = 1'b1;
            pov_d       = bus.flit_in[24:21];
            is_write_d  = bus.flit_in[20];
            state_d     = ADDR;
          end else begin
            proto_err_d = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      ISSUE_W: begin
        cnt_d     = cnt_q + CNT_W'(1);
        awvalid_d = awvalid_q & ~bus.AWREADY;
        wvalid_d  = wvalid_q & ~bus.WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d = WAIT_RSP;
        end else if (to_hit && !aw_hs && !w_hs) begin
          awvalid_d     = 1'b0;
          wvalid_d      = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      ISSUE_R: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = WAIT_RSP;
        end else if (to_hit) begin
          arvalid_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.rsp_done) begin
          state_d = IDLE;
        end else if (to_hit) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // State, VALIDs, pulses and latched transaction fields.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= IDLE;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      proto_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      pov_q         <= '0;
      is_write_q    <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      proto_err_q   <= proto_err_d;
      timeout_err_q <= timeout_err_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      pov_q         <= pov_d;
      is_write_q    <= is_write_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.flit_ready   = flit_ready;
  assign bus.AWADDR       = addr_q;
  assign bus.AWVALID      = awvalid_q;
  assign bus.WDATA        = data_q;
  assign bus.WSTRB        = WSTRB_ALL;
  assign bus.WVALID       = wvalid_q;
  assign bus.ARADDR       = addr_q;
  assign bus.ARVALID      = arvalid_q;
  assign bus.rsp_pov_addr = pov_q;
  assign bus.rsp_is_write = is_write_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.proto_err    = proto_err_q;
  assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_sna_request_sequencer.sv
// Self-checking bench for sna_request_sequencer: directed scenarios plus a
// randomized packet stream scored against an expected transaction list.
module tb_sna_request_sequencer;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sna_request_sequencer_if bus();

  sna_request_sequencer #(.TIMEOUT(8), .WSTRB_ALL(4'hF)) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .bus     (bus.slave)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit          wr;
    logic [3:0]  pov;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t obs_q[$];
  int   w_hs_cnt = 0;
  int   perr_cnt = 0;
  int   terr_cnt = 0;

  function automatic txn_t mk_txn(bit wr, logic [3:0] pov, logic [31:0] a, logic [31:0] d);
    txn_t t;
    t.wr = wr; t.pov = pov; t.addr = a; t.data = d;
    return t;
  endfunction

  function automatic logic [33:0] hdr(logic [3:0] pov, bit wr);
    logic [33:0] f;
    f = {2'b10, 32'($urandom())};
    f[24:21] = pov;
    f[20] = wr;
    return f;
  endfunction

  // Handshakes seen mid-cycle complete at the next rising edge.
  always @(negedge ACLK) begin
    if (bus.AWVALID && bus.AWREADY)
      obs_q.push_back(mk_txn(1'b1, bus.rsp_pov_addr, bus.AWADDR, bus.WDATA));
    if (bus.ARVALID && bus.ARREADY)
      obs_q.push_back(mk_txn(1'b0, bus.rsp_pov_addr, bus.ARADDR, 32'h0));
    if (bus.WVALID && bus.WREADY) w_hs_cnt <= w_hs_cnt + 1;
    if (bus.proto_err) perr_cnt <= perr_cnt + 1;
    if (bus.timeout_err) terr_cnt <= terr_cnt + 1;
  end

  task automatic send_flit(input logic [33:0] f);
    int n = 0;
    @(posedge ACLK); #1;
    bus.flit_in = f;
    bus.flit_valid = 1'b1;
    @(negedge ACLK);
    while (!bus.flit_ready && n < 300) begin n++; @(negedge ACLK); end
    checks++; if (n >= 300) begin errors++; $display("FAIL flit_accept_wait got %0d cycles exp <300", n); end
    @(posedge ACLK); #1;
    bus.flit_valid = 1'b0;
  endtask

  task automatic pulse_rsp();
    @(posedge ACLK); #1; bus.rsp_done = 1'b1;
    @(posedge ACLK); #1; bus.rsp_done = 1'b0;
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    checks++; if (bus.AWVALID !== 1'b0) begin errors++; $display("FAIL rst_awvalid got %b exp 0", bus.AWVALID); end
    checks++; if (bus.WVALID !== 1'b0) begin errors++; $display("FAIL rst_wvalid got %b exp 0", bus.WVALID); end
    checks++; if (bus.ARVALID !== 1'b0) begin errors++; $display("FAIL rst_arvalid got %b exp 0", bus.ARVALID); end
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err got %b exp 0", bus.proto_err); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err got %b exp 0", bus.timeout_err); end
    checks++; if (bus.AWADDR !== 32'h0) begin errors++; $display("FAIL rst_awaddr got %h exp 0", bus.AWADDR); end
    checks++; if (bus.ARADDR !== 32'h0) begin errors++; $display("FAIL rst_araddr got %h exp 0", bus.ARADDR); end
    checks++; if (bus.WDATA !== 32'h0) begin errors++; $display("FAIL rst_wdata got %h exp 0", bus.WDATA); end
    checks++; if (bus.rsp_pov_addr !== 4'h0) begin errors++; $display("FAIL rst_pov got %h exp 0", bus.rsp_pov_addr); end
    checks++; if (bus.rsp_is_write !== 1'b0) begin errors++; $display("FAIL rst_is_write got %b exp 0", bus.rsp_is_write); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.flit_ready !== 1'b1) begin errors++; $display("FAIL rst_flit_ready got %b exp 1", bus.flit_ready); end
    checks++; if (bus.WSTRB !== 4'hF) begin errors++; $display("FAIL rst_wstrb got %h exp F", bus.WSTRB); end
  endtask

  task automatic test_write();
    bus.AWREADY = 1'b1; bus.WREADY = 1'b1;
    send_flit(hdr(4'd5, 1'b1));
    send_flit({2'b00, 32'h0000_0040});
    send_flit({2'b01, 32'hDEAD_BEEF});
    @(negedge ACLK);
    checks++; if (bus.AWVALID !== 1'b1) begin errors++; $display("FAIL wr_awvalid got %b exp 1", bus.AWVALID); end
    checks++; if (bus.WVALID !== 1'b1) begin errors++; $display("FAIL wr_wvalid got %b exp 1", bus.WVALID); end
    checks++; if (bus.AWADDR !== 32'h40) begin errors++; $display("FAIL wr_awaddr got %h exp 40", bus.AWADDR); end
    checks++; if (bus.WDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata got %h exp deadbeef", bus.WDATA); end
    checks++; if (bus.WSTRB !== 4'hF) begin errors++; $display("FAIL wr_wstrb got %h exp F", bus.WSTRB); end
    checks++; if (bus.rsp_pov_addr !== 4'd5) begin errors++; $display("FAIL wr_pov got %0d exp 5", bus.rsp_pov_addr); end
    checks++; if (bus.rsp_is_write !== 1'b1) begin errors++; $display("FAIL wr_is_write got %b exp 1", bus.rsp_is_write); end
    checks++; if (bus.flit_ready !== 1'b0) begin errors++; $display("FAIL wr_flit_ready got %b exp 0", bus.flit_ready); end
    @(posedge ACLK); #1; bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
    @(negedge ACLK);
    checks++; if ({bus.AWVALID, bus.WVALID} !== 2'b00) begin errors++; $display("FAIL wr_valid_drop got %b exp 00", {bus.AWVALID, bus.WVALID}); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL wr_wait_busy got %b exp 1", bus.busy); end
    pulse_rsp();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wr_done_busy got %b exp 0", bus.busy); end
    checks++; if (bus.flit_ready !== 1'b1) begin errors++; $display("FAIL wr_done_ready got %b exp 1", bus.flit_ready); end
  endtask

  task automatic test_read();
    bus.ARREADY = 1'b0;
    send_flit(hdr(4'd3, 1'b0));
    send_flit({2'b00, 32'h0000_1000});
    for (int i = 0; i < 4; i++) begin
      @(negedge ACLK);
      checks++; if (bus.ARVALID !== 1'b1) begin errors++; $display("FAIL rd_arvalid_hold%0d got %b exp 1", i, bus.ARVALID); end
      checks++; if (bus.ARADDR !== 32'h1000) begin errors++; $display("FAIL rd_araddr_hold%0d got %h exp 1000", i, bus.ARADDR); end
      @(posedge ACLK); #1;
    end
    bus.ARREADY = 1'b1;
    @(negedge ACLK);
    checks++; if (bus.ARVALID !== 1'b1) begin errors++; $display("FAIL rd_arvalid_hs got %b exp 1", bus.ARVALID); end
    @(posedge ACLK); #1; bus.ARREADY = 1'b0;
    @(negedge ACLK);
    checks++; if (bus.ARVALID !== 1'b0) begin errors++; $display("FAIL rd_arvalid_drop got %b exp 0", bus.ARVALID); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rd_wait_busy got %b exp 1", bus.busy); end
    checks++; if (bus.rsp_pov_addr !== 4'd3) begin errors++; $display("FAIL rd_pov got %0d exp 3", bus.rsp_pov_addr); end
    checks++; if (bus.rsp_is_write !== 1'b0) begin errors++; $display("FAIL rd_is_write got %b exp 0", bus.rsp_is_write); end
    pulse_rsp();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rd_done_busy got %b exp 0", bus.busy); end
  endtask

  task automatic test_split_write();
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
    send_flit(hdr(4'd7, 1'b1));
    send_flit({2'b00, 32'h0000_0044});
    send_flit({2'b01, 32'h1234_5678});
    bus.AWREADY = 1'b1;
    @(negedge ACLK);
    checks++; if ({bus.AWVALID, bus.WVALID} !== 2'b11) begin errors++; $display("FAIL split_issue got %b exp 11", {bus.AWVALID, bus.WVALID}); end
    @(posedge ACLK); #1; bus.AWREADY = 1'b0; bus.rsp_done = 1'b1;
    @(negedge ACLK);
    checks++; if ({bus.AWVALID, bus.WVALID} !== 2'b01) begin errors++; $display("FAIL split_aw_done got %b exp 01", {bus.AWVALID, bus.WVALID}); end
    checks++; if (bus.flit_ready !== 1'b0) begin errors++; $display("FAIL split_ready_n2 got %b exp 0", bus.flit_ready); end
    @(posedge ACLK); #1; bus.rsp_done = 1'b0; bus.WREADY = 1'b1;
    @(negedge ACLK);
    checks++; if (bus.WVALID !== 1'b1) begin errors++; $display("FAIL split_w_hold got %b exp 1", bus.WVALID); end
    checks++; if (bus.WDATA !== 32'h12345678) begin errors++; $display("FAIL split_wdata got %h exp 12345678", bus.WDATA); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL split_early_rsp_ignored got %b exp 1", bus.busy); end
    @(posedge ACLK); #1; bus.WREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      checks++; if (bus.WVALID !== 1'b0) begin errors++; $display("FAIL split_w_drop%0d got %b exp 0", i, bus.WVALID); end
      checks++; if (bus.flit_ready !== 1'b0) begin errors++; $display("FAIL split_ready_wait%0d got %b exp 0", i, bus.flit_ready); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL split_busy_wait%0d got %b exp 1", i, bus.busy); end
      if (i < 2) begin @(posedge ACLK); #1; end
    end
    pulse_rsp();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL split_done_busy got %b exp 0", bus.busy); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL split_no_timeout got %b exp 0", bus.timeout_err); end
  endtask

  task automatic test_proto_err();
    send_flit({2'b01, 32'($urandom())});
    @(negedge ACLK);
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL pe_idle_data got %b exp 1", bus.proto_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL pe_idle_busy got %b exp 0", bus.busy); end
    @(negedge ACLK);
    checks++; if (bus.proto_err !== 1'b0) begin errors++; $display("FAIL pe_pulse_width got %b exp 0", bus.proto_err); end
    send_flit(hdr(4'd2, 1'b1));
    send_flit(hdr(4'd9, 1'b0));
    @(negedge ACLK);
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL pe_addr_hdr got %b exp 1", bus.proto_err); end
    checks++; if (bus.rsp_pov_addr !== 4'd9) begin errors++; $display("FAIL pe_relatch_pov got %0d exp 9", bus.rsp_pov_addr); end
    checks++; if (bus.rsp_is_write !== 1'b0) begin errors++; $display("FAIL pe_relatch_wr got %b exp 0", bus.rsp_is_write); end
    checks++; if ({bus.busy, bus.flit_ready} !== 2'b11) begin errors++; $display("FAIL pe_still_addr got %b exp 11", {bus.busy, bus.flit_ready}); end
    bus.ARREADY = 1'b1;
    send_flit({2'b00, 32'h0000_0080});
    @(negedge ACLK);
    checks++; if ({bus.ARVALID, bus.AWVALID} !== 2'b10) begin errors++; $display("FAIL pe_read_issue got %b exp 10", {bus.ARVALID, bus.AWVALID}); end
    checks++; if (bus.ARADDR !== 32'h80) begin errors++; $display("FAIL pe_araddr got %h exp 80", bus.ARADDR); end
    @(posedge ACLK); #1; bus.ARREADY = 1'b0;
    pulse_rsp();
    send_flit(hdr(4'd4, 1'b1));
    send_flit({2'b00, 32'h0000_0100});
    send_flit(hdr(4'd6, 1'b0));
    @(negedge ACLK);
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL pe_data_hdr got %b exp 1", bus.proto_err); end
    checks++; if (bus.rsp_pov_addr !== 4'd6) begin errors++; $display("FAIL pe_data_relatch got %0d exp 6", bus.rsp_pov_addr); end
    checks++; if ({bus.busy, bus.flit_ready} !== 2'b11) begin errors++; $display("FAIL pe_back_to_addr got %b exp 11", {bus.busy, bus.flit_ready}); end
    send_flit({2'b11, 32'($urandom())});
    @(negedge ACLK);
    checks++; if (bus.proto_err !== 1'b1) begin errors++; $display("FAIL pe_addr_invalid got %b exp 1", bus.proto_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL pe_addr_invalid_idle got %b exp 0", bus.busy); end
  endtask

  task automatic test_timeout();
    bus.ARREADY = 1'b0;
    send_flit(hdr(4'd1, 1'b0));
    send_flit({2'b00, 32'h0000_2000});
    for (int k = 1; k <= 11; k++) begin
      @(negedge ACLK);
      checks++; if (bus.timeout_err !== (k == 9)) begin errors++; $display("FAIL to_err_c%0d got %b exp %b", k, bus.timeout_err, (k == 9)); end
      checks++; if (bus.ARVALID !== (k < 9)) begin errors++; $display("FAIL to_arvalid_c%0d got %b exp %b", k, bus.ARVALID, (k < 9)); end
      checks++; if (bus.busy !== (k < 9)) begin errors++; $display("FAIL to_busy_c%0d got %b exp %b", k, bus.busy, (k < 9)); end
      @(posedge ACLK); #1;
    end
  endtask

  task automatic test_reset_mid();
    bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
    send_flit(hdr(4'd10, 1'b1));
    send_flit({2'b00, 32'h0000_0088});
    send_flit({2'b01, 32'h0000_0055});
    @(negedge ACLK);
    checks++; if (bus.AWVALID !== 1'b1) begin errors++; $display("FAIL rm_awvalid_pre got %b exp 1", bus.AWVALID); end
    #2 ARESETn = 1'b0;
    #1;
    checks++; if ({bus.AWVALID, bus.WVALID} !== 2'b00) begin errors++; $display("FAIL rm_async_drop got %b exp 00", {bus.AWVALID, bus.WVALID}); end
    checks++; if (bus.AWADDR !== 32'h0) begin errors++; $display("FAIL rm_awaddr got %h exp 0", bus.AWADDR); end
    @(posedge ACLK);
    @(negedge ACLK); ARESETn = 1'b1;
    @(negedge ACLK);
    checks++; if (bus.flit_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got %b exp 1", bus.flit_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", bus.busy); end
    checks++; if (bus.rsp_pov_addr !== 4'd0) begin errors++; $display("FAIL rm_pov got %0d exp 0", bus.rsp_pov_addr); end
  endtask

  task automatic test_random();
    txn_t exp_q[$];
    int   base = obs_q.size();
    int   w0 = w_hs_cnt;
    int   p0 = perr_cnt;
    int   t0 = terr_cnt;
    int   exp_perr = 0;
    int   exp_w = 0;
    bit   done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          bit          wr;
          logic [3:0]  pov;
          logic [31:0] a, d;
          if ($urandom_range(0, 3) == 0) begin
            logic [1:0] jt;
            case ($urandom_range(0, 2))
              0: jt = 2'b00;
              1: jt = 2'b01;
              default: jt = 2'b11;
            endcase
            send_flit({jt, 32'($urandom())});
            exp_perr++;
          end
          wr  = 1'($urandom_range(0, 1));
          pov = 4'($urandom_range(0, 15));
          a   = $urandom();
          d   = wr ? $urandom() : 32'h0;
          send_flit(hdr(pov, wr));
          send_flit({2'b00, a});
          if (wr) begin send_flit({2'b01, d}); exp_w++; end
          exp_q.push_back(mk_txn(wr, pov, a, d));
        end
        begin
          int n = 0;
          @(negedge ACLK);
          while (bus.busy && n < 100) begin n++; @(negedge ACLK); end
          checks++; if (n >= 100) begin errors++; $display("FAIL rnd_drain got %0d cycles exp <100", n); end
        end
        done = 1'b1;
      end
      begin
        int aw_d = $urandom_range(0, 2);
        int w_d  = $urandom_range(0, 2);
        int ar_d = $urandom_range(0, 2);
        int rd_d = $urandom_range(0, 2);
        while (!done) begin
          @(posedge ACLK); #1;
          if (bus.AWREADY) begin bus.AWREADY = 1'b0; aw_d = $urandom_range(0, 2); end
          else if (bus.AWVALID) begin if (aw_d == 0) bus.AWREADY = 1'b1; else aw_d--; end
          if (bus.WREADY) begin bus.WREADY = 1'b0; w_d = $urandom_range(0, 2); end
          else if (bus.WVALID) begin if (w_d == 0) bus.WREADY = 1'b1; else w_d--; end
          if (bus.ARREADY) begin bus.ARREADY = 1'b0; ar_d = $urandom_range(0, 2); end
          else if (bus.ARVALID) begin if (ar_d == 0) bus.ARREADY = 1'b1; else ar_d--; end
          if (bus.rsp_done) begin bus.rsp_done = 1'b0; rd_d = $urandom_range(0, 2); end
          else if (bus.busy && !bus.flit_ready && !bus.AWVALID && !bus.WVALID && !bus.ARVALID) begin
            if (rd_d == 0) bus.rsp_done = 1'b1; else rd_d--;
          end
        end
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0; bus.ARREADY = 1'b0; bus.rsp_done = 1'b0;
      end
    join
    checks++; if (obs_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL rnd_txn_count got %0d exp %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size() && (base + i) < obs_q.size(); i++) begin
      txn_t o;
      o = obs_q[base + i];
      checks++; if (o.wr !== exp_q[i].wr) begin errors++; $display("FAIL rnd_kind%0d got %b exp %b", i, o.wr, exp_q[i].wr); end
      checks++; if (o.pov !== exp_q[i].pov) begin errors++; $display("FAIL rnd_pov%0d got %h exp %h", i, o.pov, exp_q[i].pov); end
      checks++; if (o.addr !== exp_q[i].addr) begin errors++; $display("FAIL rnd_addr%0d got %h exp %h", i, o.addr, exp_q[i].addr); end
      checks++; if (o.data !== exp_q[i].data) begin errors++; $display("FAIL rnd_data%0d got %h exp %h", i, o.data, exp_q[i].data); end
    end
    checks++; if (w_hs_cnt - w0 !== exp_w) begin errors++; $display("FAIL rnd_w_count got %0d exp %0d", w_hs_cnt - w0, exp_w); end
    checks++; if (perr_cnt - p0 !== exp_perr) begin errors++; $display("FAIL rnd_proto_err got %0d exp %0d", perr_cnt - p0, exp_perr); end
    checks++; if (terr_cnt - t0 !== 0) begin errors++; $display("FAIL rnd_timeout_err got %0d exp 0", terr_cnt - t0); end
  endtask

  initial begin
    bus.flit_in = '0;
    bus.flit_valid = 1'b0;
    bus.AWREADY = 1'b0;
    bus.WREADY = 1'b0;
    bus.ARREADY = 1'b0;
    bus.rsp_done = 1'b0;
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    test_reset();
    @(negedge ACLK); ARESETn = 1'b1;
    test_write();
    test_read();
    test_split_write();
    test_proto_err();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
